// File: rtl/serv_pcgen.sv
// ----------------------------------------------------------------------------
// serv_pcgen - chunk-serial program counter generator.
//
// Each update sequence streams the old PC through a rotator W bits at a time
// (LSB chunk first). For each chunk it computes the incremented PC, the jump
// target and the writeback data. It then commits the new PC to the fetch
// address and issues one instruction-bus fetch.
//
// Parameters:
//   W        chunk width in bits (1, 2, 4 or 8)
//   RESET_PC PC value loaded on reset
//   WITH_CSR 1 enables trap-vector selection (i_trap / i_csr_pc)
//
// Optional feature:
//   SERV_PCGEN_COMPRESSED_EN  when defined, i_iscomp selects an increment of 2
//                             and misaligned jumps are never flagged.
//
// Ports:
//   clk            clock, all state updates on its rising edge
//   i_rst          asynchronous active-high reset
//   i_start        start one PC-update sequence (honoured only in IDLE)
//   i_jump, i_jal_or_jalr, i_utype, i_pc_rel, i_trap, i_iscomp
//                  instruction controls, held stable through SHIFT
//   i_imm, i_buf, i_csr_pc
//                  chunk-serial immediate, rs1/offset buffer, trap vector
//   o_rd           chunk-serial rd writeback data (0 outside SHIFT)
//   o_bad_pc       chunk-serial aligned jump target
//   o_ibus_adr     committed PC / fetch address
//   o_ibus_cyc     fetch request, high in FETCH
//   i_ibus_ack     fetch acknowledge, only looked at in FETCH
//   o_busy         high whenever not IDLE
//   o_done         one-cycle completion pulse
//   o_misalign     one-cycle pulse with o_done on a misaligned jump
//
// Handshake: o_ibus_cyc is held high from the first FETCH cycle until the
// cycle in which i_ibus_ack is sampled high on a rising edge; the fetch
// completes on that edge and o_ibus_cyc drops in the next cycle.
// ----------------------------------------------------------------------------
module serv_pcgen #(
    parameter int          W        = 1,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          WITH_CSR = 1
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_jump,
    input  logic         i_jal_or_jalr,
    input  logic         i_utype,
    input  logic         i_pc_rel,
    input  logic         i_trap,
    input  logic         i_iscomp,
    input  logic [W-1:0] i_imm,
    input  logic [W-1:0] i_buf,
    input  logic [W-1:0] i_csr_pc,
    output logic [W-1:0] o_rd,
    output logic [W-1:0] o_bad_pc,
    output logic [31:0]  o_ibus_adr,
    output logic         o_ibus_cyc,
    input  logic         i_ibus_ack,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_misalign
);

    localparam int         N        = 32 / W;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

`ifndef SERV_PCGEN_COMPRESSED_EN
    // Aligned target bit 1 lives in this chunk/bit position.
    localparam logic [4:0] MB_CHUNK = 5'(1 / W);
    localparam int         MB_BIT   = 1 % W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          c_inc_q, c_inc_d;
    logic          c_tgt_q, c_tgt_d;
    logic          misal_q, misal_d;
    logic [31:0]   rot_q, rot_d;
    logic [31:0]   adr_q, adr_d;
    logic [31-W:0] stage_q, stage_d;
    logic          done_q, done_d;
    logic          mis_pulse_q, mis_pulse_d;

    logic          trap_en;
    logic          first;
    logic          c_inc_in;
    logic          c_tgt_in;
    int            k;
    logic [W-1:0]  pc_chunk;
    logic [W-1:0]  inc_chunk;
    logic [W-1:0]  imm_masked;
    logic [W-1:0]  csr_masked;
    logic [W-1:0]  tgt_a;
    logic [W-1:0]  tgt_b;
    logic [W-1:0]  tgt_al;
    logic [W-1:0]  ppi_chunk;
    logic [W-1:0]  new_chunk;
    logic [W:0]    inc_sum;
    logic [W:0]    tgt_sum;

`ifndef SERV_PCGEN_COMPRESSED_EN
    logic unused_iscomp;
    assign unused_iscomp = i_iscomp;
`endif

    assign trap_en  = (WITH_CSR != 0) && i_trap;
    assign first    = (cnt_q == 5'd0);
    // Carries restart at chunk 0 so a stale carry never leaks into a new PC.
    assign c_inc_in = first ? 1'b0 : c_inc_q;
    assign c_tgt_in = first ? 1'b0 : c_tgt_q;

    // ------------------------------------------------------------------
    // Per-chunk datapath
    // ------------------------------------------------------------------
    always_comb begin : datapath
        k = 2;
`ifdef SERV_PCGEN_COMPRESSED_EN
        if (i_iscomp) k = 1;
`endif
        pc_chunk   = rot_q[W-1:0];
        inc_chunk  = '0;
        imm_masked = '0;
        csr_masked = '0;
        for (int j = 0; j < W; j++) begin
            int bitpos;
            bitpos        = int'(cnt_q) * W + j;
            inc_chunk[j]  = (bitpos == k);
            // U-type immediates only carry bits 31:12; the trap vector is
            // word aligned.
            imm_masked[j] = i_imm[j] & (bitpos >= 12);
            csr_masked[j] = i_csr_pc[j] & (bitpos >= 2);
        end

        inc_sum   = {1'b0, pc_chunk} + {1'b0, inc_chunk} + {{W{1'b0}}, c_inc_in};
        ppi_chunk = inc_sum[W-1:0];

        tgt_a   = i_pc_rel ? pc_chunk : '0;
        tgt_b   = i_utype ? imm_masked : i_buf;
        tgt_sum = {1'b0, tgt_a} + {1'b0, tgt_b} + {{W{1'b0}}, c_tgt_in};
        // Alignment clears bit 0 after the add, so the carry chain still
        // reflects the true sum.
        tgt_al  = tgt_sum[W-1:0];
        if (first) tgt_al[0] = 1'b0;

        if (trap_en)     new_chunk = csr_masked;
        else if (i_jump) new_chunk = tgt_al;
        else             new_chunk = ppi_chunk;
    end

    // ------------------------------------------------------------------
    // FSM next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin : fsm_next
        state_d     = state_q;
        cnt_d       = cnt_q;
        c_inc_d     = c_inc_q;
        c_tgt_d     = c_tgt_q;
        misal_d     = misal_q;
        rot_d       = rot_q;
        adr_d       = adr_q;
        stage_d     = stage_q;
        done_d      = 1'b0;
        mis_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 5'd0;
                    c_inc_d = 1'b0;
                    c_tgt_d = 1'b0;
                    misal_d = 1'b0;
                    rot_d   = adr_q;
                end
            end
            ST_SHIFT: begin
                rot_d   = {rot_q[W-1:0], rot_q[31:W]};
                stage_d = {new_chunk, stage_q[31-W:W]};
                c_inc_d = inc_sum[W];
                c_tgt_d = tgt_sum[W];
                cnt_d   = 5'(cnt_q + 5'd1);
`ifndef SERV_PCGEN_COMPRESSED_EN
                if (cnt_q == MB_CHUNK) misal_d = tgt_al[MB_BIT];
`endif
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 5'd0;
                    if (i_jump && !trap_en && misal_q) begin
                        // Misaligned jump: keep the old PC, skip the fetch.
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        mis_pulse_d = 1'b1;
                    end else begin
                        adr_d   = {new_chunk, stage_q};
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (i_ibus_ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            c_inc_q     <= 1'b0;
            c_tgt_q     <= 1'b0;
            misal_q     <= 1'b0;
            rot_q       <= 32'd0;
            adr_q       <= RESET_PC;
            stage_q     <= '0;
            done_q      <= 1'b0;
            mis_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            c_inc_q     <= c_inc_d;
            c_tgt_q     <= c_tgt_d;
            misal_q     <= misal_d;
            rot_q       <= rot_d;
            adr_q       <= adr_d;
            stage_q     <= stage_d;
            done_q      <= done_d;
            mis_pulse_q <= mis_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_rd       = (state_q == ST_SHIFT) ?
                        ((i_utype ? tgt_al : '0) | (i_jal_or_jalr ? ppi_chunk : '0)) : '0;
    assign o_bad_pc   = tgt_al;
    assign o_ibus_adr = adr_q;
    assign o_ibus_cyc = (state_q == ST_FETCH);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_misalign = mis_pulse_q;

endmodule
